rule_scan_ctrl: RTL and testbench
=================================

# rule_scan_ctrl

Sequencing controller for the two-rule-per-cycle decision-logic matcher in the firewall datapath. It accepts one parsed packet at a time from the packet parser and walks the rule memory in address pairs (even/odd), driving the matcher. From the per-rule hit/activity/action results it applies first-match semantics, ending the scan at the lowest-indexed active matching rule, and emits one accept/drop verdict per packet.

## Interface
Parameters:
- NUM_RULES, 256, number of rules; must be even and at most 2^ADDR_W.
- ADDR_W, 8, rule address width.
- MATCH_LAT, 2, cycles from an address pair on rule_addr1/2 with match_ena=1 to its results on hit*/active*/action*; must be at least 1.
- DEFAULT_ACCEPT, 0, verdict when no active rule matches.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pkt_valid  in  1  parser holds packet fields stable while high.
- pkt_ready  out  1  one-cycle handshake; the packet is consumed in this cycle.
- rule_addr1  out  ADDR_W  even rule address to the rule memory and matcher.
- rule_addr2  out  ADDR_W  odd rule address, always rule_addr1+1.
- match_ena  out  1  matcher enable; the current pair is being issued.
- hit1, hit2  in  1  all fields of rule 1/2 matched.
- active1, active2  in  1  rule activity bit.
- action1, action2  in  1  1 = accept, 0 = drop.
- verdict_valid  out  1  one-cycle verdict strobe.
- verdict_accept  out  1  verdict value.
- verdict_rule  out  ADDR_W  index of the deciding rule; all-ones means the default policy decided.
- busy  out  1  state is not IDLE.
- drop_cnt  out  16  count of drop verdicts; saturates at 0xFFFF.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE: when pkt_valid=1, load pair index 0 (rule_addr1=0, rule_addr2=1), set match_ena=1, clear the decided flag, and go to SCAN.
- SCAN, issue side: each cycle advance to the next pair (addresses +2). After pair NUM_RULES/2-1 is issued, hold the addresses and set match_ena=0.
- SCAN, result side: a tag pipeline {valid, pair index} of depth MATCH_LAT marks which result cycles are valid. On a valid tag:
  - if active1&hit1, decide: verdict = action1, rule = 2·pair;
  - else if active2&hit2, decide: verdict = action2, rule = 2·pair+1.
  - Rule 1 has priority when both rules in the pair hit.
  - Rules with active=0 never decide, regardless of hit.
- On a decision: flush the tag pipeline (in-flight results are discarded), set match_ena=0, go to DONE.
- If the last valid tag is consumed with no decision: verdict = DEFAULT_ACCEPT, rule = all-ones, go to DONE.
- DONE: verdict_valid=1 and pkt_ready=1 for one cycle; drop_cnt increments on a drop verdict; return to IDLE.
- pkt_valid falling during a scan is a protocol violation. It is ignored; the scan completes.
- Reset values: pkt_ready=0, match_ena=0, verdict_valid=0, verdict_accept=0, verdict_rule=0, busy=0, drop_cnt=0, rule_addr1=0, rule_addr2=1, state=IDLE, tag pipeline cleared.
- Reset during a scan aborts with no verdict. The pending packet (pkt_valid still high) is rescanned from pair 0 after release.

## Timing
- Cycle 0: IDLE samples pkt_valid=1. Pair p is presented in cycle 1+p; its result is evaluated in cycle 1+p+MATCH_LAT.
- Decision at pair p: verdict_valid in cycle 2+p+MATCH_LAT. For pair 0 with MATCH_LAT=2 this is cycle 4.
- Full miss: verdict_valid in cycle NUM_RULES/2+MATCH_LAT+1. For the defaults this is cycle 131.
- verdict_* is registered and valid only when verdict_valid=1. verdict_accept/verdict_rule hold their values until the next verdict.
- Back-to-back packets: one IDLE cycle between a DONE and the next address issue.
- Every rule address is issued at most once per packet, in ascending order.

## Structure
- Shared package fw_pkg: ADDR_W, NUM_RULES, DEFAULT_RULE_IDX (all-ones), and the scan_state_t enum {IDLE, SCAN, DONE}.
- Sub-module match_tag_pipe: a MATCH_LAT-deep shift register of {valid, pair index} with a synchronous flush input and an empty output.
- The top level holds the FSM, the address counters, the decision logic and drop_cnt.

## Test plan
- Rule 0 active, hit1=1, action1=1 on the first result (MATCH_LAT=2) -> verdict_valid and pkt_ready in cycle 4, accept=1, rule=0; later results are ignored.
- Pair 5: both rules hit and active, action1=0 -> accept=0, rule=10, drop_cnt 0->1; no address above 13 is issued.
- Pair 5: rule 10 hit but inactive, rule 11 active hit with action=1 -> accept=1, rule=11.
- No hits, defaults -> verdict in cycle 131, rule=8'hFF, accept=0; addresses 0..255 each issued exactly once.
- pkt_valid held high across two packets -> second scan issues address 0 two cycles after the first verdict_valid; drop_cnt preloaded to 0xFFFF stays at 0xFFFF on a drop.
- rst_n low while pair 40 is in flight -> all outputs return to reset values immediately; after release with pkt_valid still high, the scan restarts at address 0 and exactly one verdict is produced.

Source files
------------

// File: rtl/fw_pkg.sv
// Shared firewall datapath definitions.
//   ADDR_W / NUM_RULES : default rule memory geometry
//   DEFAULT_RULE_IDX   : verdict_rule value reported when the default policy decides
//   scan_state_t       : rule scan controller states (explicit legacy encodings)
package fw_pkg;

   localparam int unsigned ADDR_W    = 8;
   localparam int unsigned NUM_RULES = 256;

   localparam logic [ADDR_W-1:0] DEFAULT_RULE_IDX = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } scan_state_t;

endpackage

// File: rtl/rule_scan_ctrl_if.sv
// Bus between the packet parser / rule matcher and the rule scan controller.
//   master : controller side (drives addresses, match_ena, verdict, status)
//   slave  : environment side (parser handshake and matcher results)
// Signals: pkt_valid/pkt_ready, rule_addr1/rule_addr2, match_ena,
//          hit1/hit2, active1/active2, action1/action2,
//          verdict_valid/verdict_accept/verdict_rule, busy, drop_cnt.
interface rule_scan_ctrl_if #(
   parameter int unsigned ADDR_W = 8
);

   logic              pkt_valid;
   logic              pkt_ready;
   logic [ADDR_W-1:0] rule_addr1;
   logic [ADDR_W-1:0] rule_addr2;
   logic              match_ena;
   logic              hit1;
   logic              hit2;
   logic              active1;
   logic              active2;
   logic              action1;
   logic              action2;
   logic              verdict_valid;
   logic              verdict_accept;
   logic [ADDR_W-1:0] verdict_rule;
   logic              busy;
   logic [15:0]       drop_cnt;

   modport master (
      input  pkt_valid, hit1, hit2, active1, active2, action1, action2,
      output pkt_ready, rule_addr1, rule_addr2, match_ena,
             verdict_valid, verdict_accept, verdict_rule, busy, drop_cnt
   );

   modport slave (
      output pkt_valid, hit1, hit2, active1, active2, action1, action2,
      input  pkt_ready, rule_addr1, rule_addr2, match_ena,
             verdict_valid, verdict_accept, verdict_rule, busy, drop_cnt
   );

endinterface

// File: rtl/match_tag_pipe.sv
// Tag pipeline that tracks which matcher result cycles carry a real pair.
// A {valid, pair index} tag enters with each issued pair and leaves DEPTH
// cycles later, aligned with the matcher results for that pair.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush_i    : synchronous clear of all in-flight tags (input tag dropped too)
//   valid_i    : a pair is issued this cycle
//   idx_i      : pair index of the issued pair
//   valid_o    : tag at the result end is valid
//   idx_o      : pair index of the tag at the result end
//   empty_o    : no valid tag in any stage
module match_tag_pipe #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned IDX_W = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             valid_i,
   input  logic [IDX_W-1:0] idx_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             empty_o
);

   logic [DEPTH-1:0] vld_q;
   logic [IDX_W-1:0] idx_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            idx_q[i] <= '0;
         end
      end else if (flush_i) begin
         vld_q <= '0;
      end else begin
         vld_q[0] <= valid_i;
         idx_q[0] <= idx_i;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            vld_q[i] <= vld_q[i-1];
            idx_q[i] <= idx_q[i-1];
         end
      end
   end

   assign valid_o = vld_q[DEPTH-1];
   assign idx_o   = idx_q[DEPTH-1];
   assign empty_o = ~|vld_q;

endmodule

// File: rtl/rule_scan_ctrl.sv
// Rule scan controller: takes one parsed packet at a time, walks the rule
// memory two rules (even/odd) per cycle and applies first-match semantics to
// the matcher results, producing one accept/drop verdict per packet.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : rule_scan_ctrl_if master port (parser handshake, rule
//                addresses and match enable, matcher results, verdict,
//                busy and saturating drop counter)
module rule_scan_ctrl #(
   parameter int unsigned NUM_RULES      = fw_pkg::NUM_RULES,
   parameter int unsigned ADDR_W         = fw_pkg::ADDR_W,
   parameter int unsigned MATCH_LAT      = 2,
   parameter bit          DEFAULT_ACCEPT = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   rule_scan_ctrl_if.master bus
);

   import fw_pkg::*;

   localparam int unsigned       PAIR_W    = ADDR_W - 1;
   localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NUM_RULES / 2 - 1);

   scan_state_t       state_q, state_d;
   logic [PAIR_W-1:0] pair_q, pair_d;
   logic              ena_q, ena_d;
   logic              accept_q, accept_d;
   logic [ADDR_W-1:0] rule_q, rule_d;
   logic [15:0]       drop_q, drop_d;

   logic              tag_vld;
   logic [PAIR_W-1:0] tag_idx;
   logic              tag_empty;
   logic              flush;
   logic              hit_a, hit_b, decide, issue;

   assign hit_a  = bus.active1 & bus.hit1;
   assign hit_b  = bus.active2 & bus.hit2;
   assign decide = (state_q == SCAN) & tag_vld & (hit_a | hit_b);
   // The pair in flight during a decision cycle is suppressed combinationally
   // so no rule beyond the deciding window is ever presented to the matcher.
   assign issue  = ena_q & ~decide;

   match_tag_pipe #(
      .DEPTH (MATCH_LAT),
      .IDX_W (PAIR_W)
   ) u_tag_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush),
      .valid_i (issue),
      .idx_i   (pair_q),
      .valid_o (tag_vld),
      .idx_o   (tag_idx),
      .empty_o (tag_empty)
   );

   always_comb begin
      state_d  = state_q;
      pair_d   = pair_q;
      ena_d    = ena_q;
      accept_d = accept_q;
      rule_d   = rule_q;
      drop_d   = drop_q;
      flush    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.pkt_valid) begin
               pair_d  = '0;
               ena_d   = 1'b1;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (ena_q) begin
               if (pair_q == LAST_PAIR) begin
                  ena_d = 1'b0;
               end else begin
                  pair_d = pair_q + 1'b1;
               end
            end
            if (decide) begin
               flush    = 1'b1;
               ena_d    = 1'b0;
               accept_d = hit_a ? bus.action1 : bus.action2;
               // Even rule wins when both hit; odd rule index is 2*pair+1.
               rule_d   = {tag_idx, ~hit_a};
               state_d  = DONE;
            end else if ((tag_vld && tag_idx == LAST_PAIR) || (!ena_q && tag_empty)) begin
               // Second term only guards against a stuck scan if nothing is
               // left to issue or to evaluate.
               accept_d = DEFAULT_ACCEPT;
               rule_d   = '1;
               state_d  = DONE;
            end
         end
         DONE: begin
            if (!accept_q && drop_q != 16'hFFFF) begin
               drop_d = drop_q + 16'd1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         pair_q   <= '0;
         ena_q    <= 1'b0;
         accept_q <= 1'b0;
         rule_q   <= '0;
         drop_q   <= '0;
      end else begin
         state_q  <= state_d;
         pair_q   <= pair_d;
         ena_q    <= ena_d;
         accept_q <= accept_d;
         rule_q   <= rule_d;
         drop_q   <= drop_d;
      end
   end

   assign bus.rule_addr1     = {pair_q, 1'b0};
   assign bus.rule_addr2     = {pair_q, 1'b1};
   assign bus.match_ena      = issue;
   assign bus.verdict_valid  = (state_q == DONE);
   assign bus.pkt_ready      = (state_q == DONE);
   assign bus.verdict_accept = accept_q;
   assign bus.verdict_rule   = rule_q;
   assign bus.busy           = (state_q != IDLE);
   assign bus.drop_cnt       = drop_q;

endmodule

// File: tb/tb_rule_scan_ctrl.sv
// Self-checking bench for rule_scan_ctrl (defaults: 256 rules, MATCH_LAT=2,
// default drop). A behavioural matcher answers every issued pair two cycles
// later from a rule table; idle result cycles carry active/hit noise.
module tb_rule_scan_ctrl;

   import fw_pkg::*;

   localparam int LAT = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   rule_scan_ctrl_if #(.ADDR_W(8)) bus ();

   rule_scan_ctrl #(
      .NUM_RULES      (256),
      .ADDR_W         (8),
      .MATCH_LAT      (LAT),
      .DEFAULT_ACCEPT (1'b0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   string cur = "init";

   function automatic void chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s/%s: got %0d, expected %0d", cur, name, act, exp);
      end
   endfunction

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- rule table and matcher model ----------------
   logic act_t [256];
   logic hit_t [256];
   logic acc_t [256];

   logic       mv1 = 1'b0, mv2 = 1'b0;
   logic [7:0] ma1 = '0,   ma2 = '0;
   always @(posedge clk) begin
      mv1 <= bus.match_ena;
      ma1 <= bus.rule_addr1;
      mv2 <= mv1;
      ma2 <= ma1;
   end
   assign bus.hit1    = mv2 ? hit_t[ma2]               : 1'b1;
   assign bus.hit2    = mv2 ? hit_t[{ma2[7:1], 1'b1}]  : 1'b1;
   assign bus.active1 = mv2 ? act_t[ma2]               : 1'b1;
   assign bus.active2 = mv2 ? act_t[{ma2[7:1], 1'b1}]  : 1'b1;
   assign bus.action1 = mv2 ? acc_t[ma2]               : cyc[0];
   assign bus.action2 = mv2 ? acc_t[{ma2[7:1], 1'b1}]  : ~cyc[0];

   // Random background with no active&hit rule, then up to three explicit rules.
   task automatic load_table(input int ra, input logic [2:0] ca, input int rb,
                             input logic [2:0] cb, input int rc, input logic [2:0] cc);
      for (int r = 0; r < 256; r++) begin
         act_t[r] = 1'($urandom_range(0, 1));
         hit_t[r] = act_t[r] ? 1'b0 : 1'($urandom_range(0, 1));
         acc_t[r] = 1'($urandom_range(0, 1));
      end
      if (ra >= 0) {act_t[ra], hit_t[ra], acc_t[ra]} = ca;
      if (rb >= 0) {act_t[rb], hit_t[rb], acc_t[rb]} = cb;
      if (rc >= 0) {act_t[rc], hit_t[rc], acc_t[rc]} = cc;
   endtask

   // ---------------- issue monitor ----------------
   int issued = 0, order_bad = 0, last_addr = -1, first_addr = -1, first_cyc = 0;
   always @(negedge clk) begin
      if (rst_n && bus.match_ena) begin
         if (issued == 0) begin
            first_addr = int'(bus.rule_addr1);
            first_cyc  = cyc;
         end
         if (int'(bus.rule_addr1) <= last_addr || bus.rule_addr1[0] ||
             bus.rule_addr2 != bus.rule_addr1 + 8'd1)
            order_bad++;
         last_addr = int'(bus.rule_addr1);
         issued++;
      end
   end

   task automatic clear_mon();
      issued = 0; order_bad = 0; last_addr = -1; first_addr = -1;
   endtask

   // ---------------- verdict scoreboard ----------------
   typedef struct {
      logic acc;
      int   rule;
      int   lat;
   } exp_t;
   exp_t sb[$];
   int   start_cyc = 0;
   int   n_verdicts = 0;

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.verdict_valid) begin
         n_verdicts++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s/unexpected_verdict: got accept=%0d rule=%0d, expected none",
                     cur, bus.verdict_accept, bus.verdict_rule);
         end else begin
            e = sb.pop_front();
            chk("verdict_accept", bus.verdict_accept, e.acc);
            chk("verdict_rule", bus.verdict_rule, e.rule);
            chk("latency", cyc - start_cyc, e.lat);
            chk("pkt_ready", bus.pkt_ready, 1);
         end
      end
   end

   task automatic wait_verdicts(input int n);
      int k = 0;
      while (n_verdicts < n && k < 400) begin
         @(negedge clk); #1;
         k++;
      end
      if (n_verdicts < n) begin
         checks++;
         errors++;
         $display("FAIL %s/verdict_timeout: got %0d verdicts, expected %0d", cur, n_verdicts, n);
      end
   endtask

   int tb_drop = 0;

   task automatic check_reset_values();
      chk("rst_pkt_ready", bus.pkt_ready, 0);
      chk("rst_match_ena", bus.match_ena, 0);
      chk("rst_verdict_valid", bus.verdict_valid, 0);
      chk("rst_verdict_accept", bus.verdict_accept, 0);
      chk("rst_verdict_rule", bus.verdict_rule, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_drop_cnt", bus.drop_cnt, 0);
      chk("rst_addr1", bus.rule_addr1, 0);
      chk("rst_addr2", bus.rule_addr2, 1);
   endtask

   // ---------------- vector table ----------------
   // cfg bits = {active, hit, action}; rule index -1 = unused.
   typedef struct {
      string      name;
      int         ra; logic [2:0] ca;
      int         rb; logic [2:0] cb;
      int         rc; logic [2:0] cc;
      logic       exp_acc;
      int         exp_rule;
      int         exp_lat;
      int         exp_pairs;
      int         exp_max;
   } vec_t;
   vec_t vecs[8];

   task automatic run_vec(input vec_t v);
      int nv;
      exp_t e;
      cur = v.name;
      load_table(v.ra, v.ca, v.rb, v.cb, v.rc, v.cc);
      clear_mon();
      chk("idle_before", bus.busy, 0);
      nv = n_verdicts;
      e.acc = v.exp_acc; e.rule = v.exp_rule; e.lat = v.exp_lat;
      sb.push_back(e);
      start_cyc = cyc;
      bus.pkt_valid = 1'b1;
      wait_verdicts(nv + 1);
      bus.pkt_valid = 1'b0;
      @(negedge clk); #1;
      if (!v.exp_acc && tb_drop < 16'hFFFF) tb_drop++;
      chk("drop_cnt", bus.drop_cnt, tb_drop);
      chk("pairs_issued", issued, v.exp_pairs);
      chk("issue_order", order_bad, 0);
      chk("max_addr", last_addr + 1, v.exp_max);
      chk("idle_after", bus.busy, 0);
   endtask

   initial begin
      int   nv, k, vc;
      exp_t e;

      vecs[0] = '{"first_hit",     0, 3'b111,   2, 3'b110,  -1, 3'b000, 1'b1,   0,   4,   2,   3};
      vecs[1] = '{"pair5_both",   10, 3'b110,  11, 3'b111,  14, 3'b111, 1'b0,  10,   9,   7,  13};
      vecs[2] = '{"pair5_inact",  10, 3'b010,  11, 3'b111,  -1, 3'b000, 1'b1,  11,   9,   7,  13};
      vecs[3] = '{"full_miss",    -1, 3'b000,  -1, 3'b000,  -1, 3'b000, 1'b0, 255, 131, 128, 255};
      vecs[4] = '{"last_rule",   255, 3'b111,  -1, 3'b000,  -1, 3'b000, 1'b1, 255, 131, 128, 255};
      vecs[5] = '{"last_pair",   254, 3'b110, 255, 3'b111,  -1, 3'b000, 1'b0, 254, 131, 128, 255};
      vecs[6] = '{"act_nohit",     7, 3'b101,   9, 3'b110,  -1, 3'b000, 1'b0,   9,   8,   6,  11};
      vecs[7] = '{"pair1_odd",     3, 3'b111,   1, 3'b011,  -1, 3'b000, 1'b1,   3,   5,   3,   5};

      rst_n = 1'b0;
      bus.pkt_valid = 1'b0;
      load_table(-1, 3'b000, -1, 3'b000, -1, 3'b000);
      repeat (3) @(negedge clk);
      #1;
      cur = "reset";
      check_reset_values();
      rst_n = 1'b1;
      @(negedge clk); #1;

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Reset while pair 40 is in flight, packet still pending afterwards.
      cur = "mid_reset";
      load_table(-1, 3'b000, -1, 3'b000, -1, 3'b000);
      clear_mon();
      bus.pkt_valid = 1'b1;
      k = 0;
      while (last_addr != 80 && k < 200) begin
         @(negedge clk); #1;
         k++;
      end
      if (last_addr != 80) begin
         checks++;
         errors++;
         $display("FAIL %s/pair40_timeout: got last address %0d, expected 80", cur, last_addr);
      end
      rst_n = 1'b0;
      #1;
      check_reset_values();
      tb_drop = 0;
      @(negedge clk); #1;
      load_table(20, 3'b110, -1, 3'b000, -1, 3'b000);
      clear_mon();
      nv = n_verdicts;
      e.acc = 1'b0; e.rule = 20; e.lat = 14;
      sb.push_back(e);
      start_cyc = cyc;
      rst_n = 1'b1;
      wait_verdicts(nv + 1);
      bus.pkt_valid = 1'b0;
      tb_drop++;
      repeat (20) @(negedge clk);
      #1;
      chk("one_verdict", n_verdicts - nv, 1);
      chk("restart_addr", first_addr, 0);
      chk("pairs_issued", issued, 12);
      chk("issue_order", order_bad, 0);
      chk("drop_cnt", bus.drop_cnt, tb_drop);

      // Saturated drop counter and back-to-back packets.
      cur = "b2b_sat";
      force dut.drop_q = 16'hFFFF;
      @(negedge clk); #1;
      release dut.drop_q;
      @(negedge clk); #1;
      tb_drop = 16'hFFFF;
      chk("drop_preload", bus.drop_cnt, tb_drop);
      load_table(0, 3'b110, -1, 3'b000, -1, 3'b000);
      clear_mon();
      nv = n_verdicts;
      e.acc = 1'b0; e.rule = 0; e.lat = 4;
      sb.push_back(e);
      sb.push_back(e);
      start_cyc = cyc;
      bus.pkt_valid = 1'b1;
      wait_verdicts(nv + 1);
      vc = cyc;
      start_cyc = cyc + 1;
      clear_mon();
      wait_verdicts(nv + 2);
      bus.pkt_valid = 1'b0;
      chk("b2b_gap", first_cyc - vc, 2);
      chk("b2b_first_addr", first_addr, 0);
      @(negedge clk); #1;
      chk("drop_saturated", bus.drop_cnt, tb_drop);
      chk("sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
